// File: rtl/stack_ctrl_if.sv
// Bundles the control-FSM request/response signals and the stack RAM port
// of stack_ctrl; the controller uses the slave side.
interface stack_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  flush;
    logic                  clr_err;
    logic                  req_ready;
    logic                  pop_valid;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [ADDR_WIDTH:0]   tos_pointer;
    logic                  full;
    logic                  empty;
    logic                  overflow_err;
    logic                  underflow_err;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  push, pop, push_data, flush, clr_err, ram_rdata,
        output req_ready, pop_valid, pop_data, tos_pointer, full, empty,
               overflow_err, underflow_err, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output push, pop, push_data, flush, clr_err, ram_rdata,
        input  req_ready, pop_valid, pop_data, tos_pointer, full, empty,
               overflow_err, underflow_err, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/stack_ctrl.sv
// Data-stack controller: turns push/pop/replace-top requests into single-port
// RAM cycles and owns the entry count plus sticky overflow/underflow flags.
module stack_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    stack_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_e;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  swap_q, swap_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  full, empty;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        data_d      = data_q;
        swap_d      = swap_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q & ~bus.clr_err;
        unf_d       = unf_q & ~bus.clr_err;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.push && !bus.pop) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        data_d  = bus.push_data;
                        addr_d  = ADDR_WIDTH'(count_q);
                        swap_d  = 1'b0;
                        state_d = WRITE;
                    end
                end else if (bus.pop) begin
                    if (empty) begin
                        unf_d = 1'b1;
                        // A replace-top on an empty stack degrades to a plain push.
                        if (bus.push) begin
                            data_d  = bus.push_data;
                            addr_d  = ADDR_WIDTH'(count_q);
                            swap_d  = 1'b0;
                            state_d = WRITE;
                        end
                    end else begin
                        swap_d  = bus.push;
                        data_d  = bus.push_data;
                        addr_d  = ADDR_WIDTH'(count_q - ONE);
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = data_q;
                if (!swap_q) count_d = count_q + ONE;
                state_d = IDLE;
            end
            READ: begin
                ram_addr = ADDR_WIDTH'(count_q - ONE);
                if (!swap_q) count_d = count_q - ONE;
                state_d = WAIT;
            end
            WAIT: begin
                pop_data_d  = bus.ram_rdata;
                pop_valid_d = 1'b1;
                state_d     = swap_q ? WRITE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush drops any request and aborts the operation in flight; errors stay.
        if (bus.flush) begin
            state_d     = IDLE;
            count_d     = '0;
            swap_d      = 1'b0;
            pop_valid_d = 1'b0;
            pop_data_d  = pop_data_q;
            ovf_d       = ovf_q & ~bus.clr_err;
            unf_d       = unf_q & ~bus.clr_err;
            ram_we      = 1'b0;
        end
        if (rst) ram_we = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            swap_q      <= 1'b0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            swap_q      <= swap_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.pop_valid     = pop_valid_q;
    assign bus.pop_data      = pop_data_q;
    assign bus.tos_pointer   = count_q;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
    assign bus.ram_addr      = ram_addr;
    assign bus.ram_we        = ram_we;
    assign bus.ram_wdata     = ram_wdata;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack RAM; popped words are
// checked against a queue of expected values by an independent monitor.
module tb_stack_ctrl;
    logic clk = 1'b0;
    logic rst;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mem [32];

    stack_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus ();

    stack_ctrl #(.DATA_WIDTH(16), .DEPTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port RAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every pop_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.pop_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected pop_valid", {31'd0, bus.pop_valid}, 32'd0);
            else check("pop_data", {16'd0, bus.pop_data}, {16'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.req_ready !== 1'b1) check("req_ready timeout", {31'd0, bus.req_ready}, 32'd1);
    endtask

    // Presents one request in a ready cycle N; returns in cycle N+1.
    task automatic issue(input logic p, input logic q, input logic [15:0] d);
        wait_ready();
        bus.push      = p;
        bus.pop       = q;
        bus.push_data = d;
        tick();
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = '0;
    endtask

    task automatic push_word(input logic [15:0] d);
        issue(1'b1, 1'b0, d);
        wait_ready();
    endtask

    task automatic pop_word(input logic [15:0] e);
        exp_q.push_back(e);
        issue(1'b0, 1'b1, 16'h0);
        wait_ready();
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0;
        bus.flush = 1'b0; bus.clr_err = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst tos", {26'd0, bus.tos_pointer}, 32'd0);
        check("rst empty", {31'd0, bus.empty}, 32'd1);
        check("rst full", {31'd0, bus.full}, 32'd0);
        check("rst errs", {30'd0, bus.overflow_err, bus.underflow_err}, 32'd0);
        check("rst pop_valid", {31'd0, bus.pop_valid}, 32'd0);
        check("rst pop_data", {16'd0, bus.pop_data}, 32'd0);
        check("rst ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst ram_addr", {27'd0, bus.ram_addr}, 32'd0);
        check("rst ram_wdata", {16'd0, bus.ram_wdata}, 32'd0);

        // Push latency: write in N+1, ready and count in N+2.
        issue(1'b1, 1'b0, 16'h1234);
        check("push N+1 ram_we", {31'd0, bus.ram_we}, 32'd1);
        check("push N+1 ram_addr", {27'd0, bus.ram_addr}, 32'd0);
        check("push N+1 ram_wdata", {16'd0, bus.ram_wdata}, 32'h1234);
        check("push N+1 req_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("push N+2 req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("push N+2 tos", {26'd0, bus.tos_pointer}, 32'd1);
        push_word(16'hBEEF);
        check("mem0", {16'd0, mem[0]}, 32'h1234);
        check("mem1", {16'd0, mem[1]}, 32'hBEEF);
        check("tos after 2 pushes", {26'd0, bus.tos_pointer}, 32'd2);

        // Pop latency: address in N+1, count down at end of N+1, data in N+3.
        exp_q.push_back(16'hBEEF);
        issue(1'b0, 1'b1, 16'h0);
        check("pop N+1 ram_addr", {27'd0, bus.ram_addr}, 32'd1);
        check("pop N+1 ram_we", {31'd0, bus.ram_we}, 32'd0);
        tick();
        check("pop N+2 tos", {26'd0, bus.tos_pointer}, 32'd1);
        check("pop N+2 pop_valid", {31'd0, bus.pop_valid}, 32'd0);
        check("pop N+2 req_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("pop N+3 pop_valid", {31'd0, bus.pop_valid}, 32'd1);
        check("pop N+3 req_ready", {31'd0, bus.req_ready}, 32'd1);
        pop_word(16'h1234);
        check("empty after pops", {31'd0, bus.empty}, 32'd1);
        check("tos after pops", {26'd0, bus.tos_pointer}, 32'd0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 32; i++) push_word(16'(i));
        check("full at 32", {31'd0, bus.full}, 32'd1);
        check("tos at 32", {26'd0, bus.tos_pointer}, 32'd32);
        check("mem31", {16'd0, mem[31]}, 32'd31);
        issue(1'b1, 1'b0, 16'hAAAA);
        check("overflow ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("overflow_err", {31'd0, bus.overflow_err}, 32'd1);
        check("overflow req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("overflow tos", {26'd0, bus.tos_pointer}, 32'd32);
        pop_word(16'd31);
        check("tos after pop from full", {26'd0, bus.tos_pointer}, 32'd31);
        pulse_flush();
        check("flush tos", {26'd0, bus.tos_pointer}, 32'd0);
        check("flush keeps overflow_err", {31'd0, bus.overflow_err}, 32'd1);

        // Underflow, replace-top on empty, and clr_err.
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        check("clr overflow_err", {31'd0, bus.overflow_err}, 32'd0);
        issue(1'b0, 1'b1, 16'h0);
        check("underflow_err", {31'd0, bus.underflow_err}, 32'd1);
        check("underflow req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick(); tick();
        check("underflow no pop_valid", {31'd0, bus.pop_valid}, 32'd0);
        issue(1'b1, 1'b1, 16'h0055);
        check("swap-empty ram_we", {31'd0, bus.ram_we}, 32'd1);
        wait_ready();
        check("swap-empty tos", {26'd0, bus.tos_pointer}, 32'd1);
        check("swap-empty mem0", {16'd0, mem[0]}, 32'h0055);
        pulse_flush();
        bus.clr_err = 1'b1;
        issue(1'b0, 1'b1, 16'h0);
        bus.clr_err = 1'b0;
        check("set beats clr", {31'd0, bus.underflow_err}, 32'd1);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        check("clr both errs", {30'd0, bus.overflow_err, bus.underflow_err}, 32'd0);

        // Replace-top on [0x0001, 0x0002].
        push_word(16'h0001);
        push_word(16'h0002);
        exp_q.push_back(16'h0002);
        issue(1'b1, 1'b1, 16'h00FF);
        check("swap N+1 ram_addr", {27'd0, bus.ram_addr}, 32'd1);
        tick();
        tick();
        check("swap N+3 pop_valid", {31'd0, bus.pop_valid}, 32'd1);
        check("swap N+3 ram_we", {31'd0, bus.ram_we}, 32'd1);
        check("swap N+3 ram_addr", {27'd0, bus.ram_addr}, 32'd1);
        check("swap N+3 ram_wdata", {16'd0, bus.ram_wdata}, 32'h00FF);
        check("swap N+3 req_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("swap N+4 req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("swap N+4 tos", {26'd0, bus.tos_pointer}, 32'd2);
        check("swap mem1", {16'd0, mem[1]}, 32'h00FF);

        // Flush during WAIT aborts the pop.
        pulse_flush();
        push_word(16'h000A);
        push_word(16'h000B);
        push_word(16'h000C);
        issue(1'b0, 1'b1, 16'h0);
        tick();
        pulse_flush();
        check("abort no pop_valid", {31'd0, bus.pop_valid}, 32'd0);
        check("abort tos", {26'd0, bus.tos_pointer}, 32'd0);
        check("abort req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort pop_data held", {16'd0, bus.pop_data}, 32'h0002);

        // Reset in the middle of a WRITE.
        issue(1'b0, 1'b1, 16'h0);
        check("pre-rst underflow_err", {31'd0, bus.underflow_err}, 32'd1);
        issue(1'b1, 1'b0, 16'h7777);
        check("mid-write ram_we", {31'd0, bus.ram_we}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post-rst ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("post-rst ram_addr", {27'd0, bus.ram_addr}, 32'd0);
        check("post-rst tos", {26'd0, bus.tos_pointer}, 32'd0);
        check("post-rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("post-rst underflow_err", {31'd0, bus.underflow_err}, 32'd0);
        check("post-rst pop_data", {16'd0, bus.pop_data}, 32'd0);
        check("post-rst pop_valid", {31'd0, bus.pop_valid}, 32'd0);

        tick(); tick();
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
